// File: rtl/mac_mod_761.sv
`default_nettype none
// ============================================================================
// Module      : mac_mod_761
// Description : Streaming modular multiply-accumulate over Z_761.
//               Accepts a frame of operand pairs (a, b) and returns
//               sum(a*b) mod 761 together with the frame's beat count.
//               Three-stage pipeline:
//                 S1 - raw 20-bit product
//                 S2 - Barrett reduction mod 761
//                 S3 - modular accumulate and result load
//               The whole pipeline stalls while a result waits for its
//               consumer.
// Ports       : clk, rst       - clock (rising edge), async active-high reset
//               in_valid/in_ready/in_a/in_b/in_last - operand beat stream
//               out_valid/out_ready/out_data/out_count - per-frame result
//               err            - range-check flag, only present when
//                                MAC_MOD_761_RANGE_CHECK_EN is defined
// Options     : MAC_MOD_761_RANGE_CHECK_EN - adds sticky operand range flag
// Revision    : 1.0 - initial release
// ============================================================================
module mac_mod_761 #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_a,
    input  logic [9:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_data,
    output logic [CNT_W-1:0] out_count
`ifdef MAC_MOD_761_RANGE_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [10:0]      c_mod     = 11'd761;
    // mu = floor(2^20 / 761). The quotient estimate is then short by at
    // most one, so a single conditional subtraction makes S2 exact over the
    // full 20-bit product range.
    localparam logic [31:0]      c_mu      = 32'd1377;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Pipeline registers
    logic             r_s1_valid;
    logic             r_s1_last;
    logic [19:0]      r_s1_p;
    logic             r_s2_valid;
    logic             r_s2_last;
    logic [9:0]       r_s2_r;
    logic [9:0]       r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [9:0]       r_out_data;
    logic [CNT_W-1:0] r_out_count;

    logic             w_adv;
    logic [10:0]      w_qt;
    logic [10:0]      w_qm;
    logic [10:0]      w_r0;
    logic [9:0]       w_r1;
    logic [10:0]      w_sum;
    logic [9:0]       w_acc_next;
    logic [CNT_W-1:0] w_cnt_inc;

    // Every stage moves together; nothing moves while a result is stuck.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv && !rst;

    // Barrett: q ~= (p * mu) >> 20; remainder p - q*761 lies in [0, 1521].
    // Only the low 11 bits of p - q*761 are needed since the true value
    // fits, so the subtraction is done modulo 2^11.
    assign w_qt = 11'(({12'd0, r_s1_p} * c_mu) >> 20);
    assign w_qm = 11'(w_qt * c_mod);
    assign w_r0 = r_s1_p[10:0] - w_qm;
    assign w_r1 = (w_r0 >= c_mod) ? 10'(w_r0 - c_mod) : w_r0[9:0];

    // Modular accumulate: both inputs < 761, so one subtraction suffices.
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_s2_r};
    assign w_acc_next = (w_sum >= c_mod) ? 10'(w_sum - c_mod) : w_sum[9:0];

    // Counter saturates rather than wrapping on over-long frames.
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_p      <= 20'd0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_r      <= 10'd0;
            r_acc       <= 10'd0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 10'd0;
            r_out_count <= '0;
        end else if (w_adv) begin
            // S1
            r_s1_valid <= in_valid;
            r_s1_last  <= in_last;
            r_s1_p     <= 20'(in_a) * 20'(in_b);
            // S2
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_r     <= w_r1;
            // S3: w_adv implies any previous result is consumed this cycle,
            // so out_valid reflects only a newly loaded result.
            r_out_valid <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                if (r_s2_last) begin
                    r_out_data  <= w_acc_next;
                    r_out_count <= w_cnt_inc;
                    r_acc       <= 10'd0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

`ifdef MAC_MOD_761_RANGE_CHECK_EN
    logic r_err;
    logic w_bad_beat;

    assign w_bad_beat = in_valid && in_ready &&
                        ((in_a >= c_mod[9:0]) || (in_b >= c_mod[9:0]));

    // A bad beat accepted alongside a result handshake belongs to a later
    // frame, so setting takes priority over clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_bad_beat) begin
            r_err <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_mod_761.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_mod_761
// Description : Directed self-checking bench for mac_mod_761.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_mod_761;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [9:0]       in_a = 10'd0;
    logic [9:0]       in_b = 10'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [9:0]       out_data;
    logic [CNT_W-1:0] out_count;
`ifdef MAC_MOD_761_RANGE_CHECK_EN
    logic             err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;

    int q_data[$];
    int q_count[$];
    int q_cyc[$];

    mac_mod_761 #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef MAC_MOD_761_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every result handshake, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                q_data.push_back(int'(out_data));
                q_count.push_back(int'(out_count));
                q_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    // Present one beat and return at the negedge after it was accepted.
    task automatic send(input logic [9:0] a, input logic [9:0] b, input logic last);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        while (in_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        last_acc_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        int g;
        g = 0;
        while (q_data.size() < n && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        ok = (q_data.size() >= n);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_count.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 10'd0) begin failures++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if (out_count !== '0) begin failures++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        bit ok;
        int n;
        clear_q();
        send(10'd760, 10'd760, 1'b1);
        n = last_acc_cyc;
        idle();
        wait_results(1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL single_timeout: results=%0d want 1", q_data.size());
        end else begin
            checks++; if (q_data[0] != 1) begin failures++; $display("FAIL single_data: got %0d want 1", q_data[0]); end
            checks++; if (q_count[0] != 1) begin failures++; $display("FAIL single_count: got %0d want 1", q_count[0]); end
            checks++; if (q_cyc[0] != n + 3) begin failures++; $display("FAIL single_latency: got cycle %0d want %0d", q_cyc[0], n + 3); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_q();
        send(10'd2, 10'd3, 1'b0);
        send(10'd4, 10'd5, 1'b0);
        send(10'd6, 10'd7, 1'b1);
        send(10'd1, 10'd1, 1'b1);
        idle();
        wait_results(2, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL b2b_timeout: results=%0d want 2", q_data.size());
        end else begin
            checks++; if (q_data[0] != 68) begin failures++; $display("FAIL b2b_data0: got %0d want 68", q_data[0]); end
            checks++; if (q_count[0] != 3) begin failures++; $display("FAIL b2b_count0: got %0d want 3", q_count[0]); end
            checks++; if (q_data[1] != 1) begin failures++; $display("FAIL b2b_data1: got %0d want 1", q_data[1]); end
            checks++; if (q_count[1] != 1) begin failures++; $display("FAIL b2b_count1: got %0d want 1", q_count[1]); end
            checks++; if (q_cyc[1] != q_cyc[0] + 1) begin failures++; $display("FAIL b2b_spacing: got cycle %0d want %0d", q_cyc[1], q_cyc[0] + 1); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_q();
        send(10'd380, 10'd2, 1'b0);
        send(10'd1, 10'd1, 1'b1);
        idle();
        wait_results(1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wrap_timeout: results=%0d want 1", q_data.size());
        end else begin
            checks++; if (q_data[0] != 0) begin failures++; $display("FAIL wrap_data: got %0d want 0", q_data[0]); end
            checks++; if (q_count[0] != 2) begin failures++; $display("FAIL wrap_count: got %0d want 2", q_count[0]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int g;
        clear_q();
        out_ready = 1'b0;
        send(10'd10, 10'd10, 1'b1);
        send(10'd2, 10'd2, 1'b0);
        send(10'd3, 10'd3, 1'b1);
        // Next frame's only beat waits at the input during the stall.
        in_valid = 1'b1; in_a = 10'd5; in_b = 10'd5; in_last = 1'b1;
        g = 0;
        #1;
        while (out_valid !== 1'b1 && g < 50) begin @(negedge clk); #1; g++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== 10'd100) begin failures++; $display("FAIL bp_data[%0d]: got %0d want 100", i, out_data); end
            checks++; if (out_count !== 11'd1) begin failures++; $display("FAIL bp_count[%0d]: got %0d want 1", i, out_count); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(10'd5, 10'd5, 1'b1);
        idle();
        wait_results(3, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (q_data.size() != 3) begin
            failures++; $display("FAIL bp_result_count: got %0d want 3", q_data.size());
        end else begin
            checks++; if (q_data[0] != 100 || q_count[0] != 1) begin failures++; $display("FAIL bp_res0: got %0d/%0d want 100/1", q_data[0], q_count[0]); end
            checks++; if (q_data[1] != 13 || q_count[1] != 2) begin failures++; $display("FAIL bp_res1: got %0d/%0d want 13/2", q_data[1], q_count[1]); end
            checks++; if (q_data[2] != 25 || q_count[2] != 1) begin failures++; $display("FAIL bp_res2: got %0d/%0d want 25/1", q_data[2], q_count[2]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        send(10'd7, 10'd7, 1'b0);
        send(10'd8, 10'd8, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_outputs: valid=%b ready=%b want 0/0", out_valid, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_q();
        send(10'd3, 10'd3, 1'b1);
        idle();
        wait_results(1, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (q_data.size() != 1) begin
            failures++; $display("FAIL midrst_result_count: got %0d want 1", q_data.size());
        end else begin
            checks++; if (q_data[0] != 9 || q_count[0] != 1) begin failures++; $display("FAIL midrst_res: got %0d/%0d want 9/1", q_data[0], q_count[0]); end
        end
    endtask

    // Single-beat frames across the full 10x10-bit product range.
    task automatic test_reduction();
        bit ok;
        int exp_r[$];
        logic [9:0] a, b;
        clear_q();
        for (int i = 0; i < 48; i++) begin
            if (i == 0) begin a = 10'd1023; b = 10'd1023; end
            else if (i == 1) begin a = 10'd761; b = 10'd1; end
            else if (i == 2) begin a = 10'd0; b = 10'd1023; end
            else begin a = 10'($urandom_range(1023, 0)); b = 10'($urandom_range(1023, 0)); end
            exp_r.push_back((int'(a) * int'(b)) % 761);
            send(a, b, 1'b1);
        end
        idle();
        wait_results(48, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL red_timeout: results=%0d want 48", q_data.size());
        end else begin
            for (int i = 0; i < 48; i++) begin
                checks++; if (q_data[i] != exp_r[i]) begin failures++; $display("FAIL red_data[%0d]: got %0d want %0d", i, q_data[i], exp_r[i]); end
            end
        end
    endtask

    // Long frame with bubbles between beats.
    task automatic test_bubbles();
        bit ok;
        int sum;
        logic [9:0] a, b;
        clear_q();
        sum = 0;
        for (int i = 0; i < 20; i++) begin
            a = 10'($urandom_range(1023, 0));
            b = 10'($urandom_range(1023, 0));
            sum = (sum + int'(a) * int'(b)) % 761;
            send(a, b, (i == 19) ? 1'b1 : 1'b0);
            if (i % 3 == 1) begin idle(); repeat (2) @(negedge clk); end
        end
        idle();
        wait_results(1, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL bub_timeout: results=%0d want 1", q_data.size());
        end else begin
            checks++; if (q_data[0] != sum) begin failures++; $display("FAIL bub_data: got %0d want %0d", q_data[0], sum); end
            checks++; if (q_count[0] != 20) begin failures++; $display("FAIL bub_count: got %0d want 20", q_count[0]); end
        end
    endtask

`ifdef MAC_MOD_761_RANGE_CHECK_EN
    task automatic test_range_check();
        int g;
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_idle: got %b want 0", err); end
        clear_q();
        out_ready = 1'b0;
        send(10'd800, 10'd5, 1'b1);
        idle();
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", err); end
        g = 0;
        while (out_valid !== 1'b1 && g < 50) begin @(negedge clk); #1; g++; end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_hold: got %b want 1", err); end
        checks++; if (out_data !== 10'd195) begin failures++; $display("FAIL err_data: got %0d want 195", out_data); end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_mid_frame();
        test_reduction();
        test_bubbles();
`ifdef MAC_MOD_761_RANGE_CHECK_EN
        test_range_check();
`endif
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
